change_dispenser: RTL and testbench

Pays out a change amount as physical coins, one per handshake with the coin-ejector mechanism. It is the pay-out end of the vending datapath: `coin_counter` accumulates inserted money and produces a change amount in cents, and this block turns that amount into a greedy sequence of quarters, dimes and nickels. Each coin is presented to the ejector and held until the ejector acknowledges it. The block reports the coins paid and signals completion.

---
 rtl/vend_pkg.sv | 36 +++
 rtl/coin_select.sv | 27 ++
 rtl/change_dispenser.sv | 113 +++++++++++
 tb/tb_change_dispenser.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending definitions: money width, coin encodings and denominations,
// and the change_dispenser state enumeration.
package vend_pkg;

  localparam int MONEY_W = 10;

  localparam logic [MONEY_W-1:0] NICKEL_C  = 10'd5;
  localparam logic [MONEY_W-1:0] DIME_C    = 10'd10;
  localparam logic [MONEY_W-1:0] QUARTER_C = 10'd25;
  localparam logic [MONEY_W-1:0] DOLLAR_C  = 10'd100;

  typedef enum logic [1:0] {
    COIN_NICKEL  = 2'd0,
    COIN_DIME    = 2'd1,
    COIN_QUARTER = 2'd2,
    COIN_DOLLAR  = 2'd3
  } coin_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_EJECT  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Face value in cents of a coin type.
  function automatic logic [MONEY_W-1:0] coin_value(input coin_t c);
    case (c)
      COIN_DIME:    coin_value = DIME_C;
      COIN_QUARTER: coin_value = QUARTER_C;
      COIN_DOLLAR:  coin_value = DOLLAR_C;
      default:      coin_value = NICKEL_C;
    endcase
  endfunction

endpackage

// File: rtl/coin_select.sv
// Greedy coin chooser: largest enabled denomination not exceeding the
// amount still owed. The dollar compare exists only when DOLLAR_COIN_EN
// is defined.
module coin_select
  import vend_pkg::*;
(
  input  logic [MONEY_W-1:0] remaining,
  output coin_t              coinType,
  output logic [MONEY_W-1:0] coinValue
);

  // Compare chain from the largest coin down; nickel is the fallback.
  always_comb begin
    coinType = COIN_NICKEL;
`ifdef DOLLAR_COIN_EN
    if (remaining >= DOLLAR_C)
      coinType = COIN_DOLLAR;
    else
`endif
    if (remaining >= QUARTER_C)
      coinType = COIN_QUARTER;
    else if (remaining >= DIME_C)
      coinType = COIN_DIME;
    coinValue = coin_value(coinType);
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays a change amount as a greedy sequence of coins,
// one coin per ejector handshake. Optional dollar coin via DOLLAR_COIN_EN.
//
// Ejector handshake: coinEject is the valid, coinAck the ready. A coin is
// transferred in any cycle where both are high; until then coinEject and
// coinType stay constant, and coinAck is ignored when coinEject is low.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [MONEY_W-1:0] changeIn,
  input  logic               changeValid,
  input  logic               coinAck,
  output logic               coinEject,
  output logic [1:0]         coinType,
  output logic [MONEY_W-1:0] remaining,
  output logic [CNT_W-1:0]   coinCount,
  output logic               busy,
  output logic               done,
  output logic               error,
  output state_t             debugState
);

  state_t             state;
  state_t             nextState;
  logic [MONEY_W-1:0] remainingR;
  logic [CNT_W-1:0]   countR;
  coin_t              typeR;
  logic [MONEY_W-1:0] valueR;
  logic               errorR;
  coin_t              selType;
  logic [MONEY_W-1:0] selValue;
  logic [MONEY_W-1:0] changeMod;
  logic               isMult5;
  logic               accept;

  coin_select u_coin_select (
    .remaining (remainingR),
    .coinType  (selType),
    .coinValue (selValue)
  );

  assign changeMod = changeIn % NICKEL_C;
  assign isMult5   = (changeMod == '0);
  assign accept    = changeValid && (state == ST_IDLE) && isMult5;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= nextState;
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:   if (accept) nextState = (changeIn == '0) ? ST_DONE : ST_SELECT;
      ST_SELECT: nextState = ST_EJECT;
      ST_EJECT:  if (coinAck) nextState = (remainingR == valueR) ? ST_DONE : ST_SELECT;
      ST_DONE:   nextState = ST_IDLE;
      default:   nextState = ST_IDLE;
    endcase
  end

  // Datapath: amount owed, coin counter, latched coin choice, reject pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      remainingR <= '0;
      countR     <= '0;
      typeR      <= COIN_NICKEL;
      valueR     <= '0;
      errorR     <= 1'b0;
    end else begin
      errorR <= changeValid && ((state != ST_IDLE) || !isMult5);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            remainingR <= changeIn;
            countR     <= '0;
          end
        end
        ST_SELECT: begin
          typeR  <= selType;
          valueR <= selValue;
        end
        ST_EJECT: begin
          if (coinAck) begin
            // Chosen coin never exceeds remainingR, so no underflow.
            remainingR <= remainingR - valueR;
            if (countR != '1) countR <= countR + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and datapath registers.
  always_comb begin
    coinEject  = (state == ST_EJECT);
    busy       = (state != ST_IDLE);
    done       = (state == ST_DONE);
    coinType   = typeR;
    remaining  = remainingR;
    coinCount  = countR;
    error      = errorR;
    debugState = state;
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed cases plus random jobs,
// a greedy reference model and a scoreboard fed by a monitor.
module tb_change_dispenser;
  import vend_pkg::*;

  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic [9:0]       changeIn;
  logic             changeValid;
  logic             coinAck;
  logic             coinEject;
  logic [1:0]       coinType;
  logic [9:0]       remaining;
  logic [CNT_W-1:0] coinCount;
  logic             busy;
  logic             done;
  logic             error;
  state_t           debugState;

  change_dispenser #(.CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .changeIn    (changeIn),
    .changeValid (changeValid),
    .coinAck     (coinAck),
    .coinEject   (coinEject),
    .coinType    (coinType),
    .remaining   (remaining),
    .coinCount   (coinCount),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .debugState  (debugState)
  );

  // Clock.
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int exp_coin_q[$];
  int exp_done_q[$];
  int exp_err_q[$];
  int ack_delay = 0;
  bit stray_en  = 1'b0;
  int wait_cnt  = 0;
  int last_n    = 0;
  bit dollar_en;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int denom(input int t);
    case (t)
      0: return 5;
      1: return 10;
      2: return 25;
      default: return 100;
    endcase
  endfunction

  // Reference model: coin counts by integer division, largest coin first.
  task automatic model_push(input int amt, output int n);
    int r;
    int k;
    r = amt;
    n = 0;
    if (dollar_en) begin
      k = r / 100; r = r % 100;
      repeat (k) exp_coin_q.push_back(3);
      n += k;
    end
    k = r / 25; r = r % 25;
    repeat (k) exp_coin_q.push_back(2);
    n += k;
    k = r / 10; r = r % 10;
    repeat (k) exp_coin_q.push_back(1);
    n += k;
    k = r / 5;
    repeat (k) exp_coin_q.push_back(0);
    n += k;
    exp_done_q.push_back(n);
  endtask

  // Ejector model: acks after ack_delay idle eject cycles; optional stray acks.
  initial begin
    coinAck = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (reset) begin
        coinAck  = 1'b0;
        wait_cnt = 0;
      end else if (coinEject) begin
        if (wait_cnt >= ack_delay) begin
          coinAck  = 1'b1;
          wait_cnt = 0;
        end else begin
          coinAck  = 1'b0;
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        coinAck  = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  // Monitor: compares ejected coins, completions and rejects against the queues.
  bit         prev_eject = 1'b0;
  bit         prev_ack   = 1'b0;
  logic [1:0] prev_type  = '0;
  logic [9:0] prev_rem   = '0;
  always @(negedge clock) begin
    if (reset) begin
      prev_eject = 1'b0;
      prev_ack   = 1'b0;
    end else begin
      if (prev_eject && prev_ack)
        check("remaining_step", int'(remaining), int'(prev_rem) - denom(int'(prev_type)));
      if (coinEject) begin
        if (prev_eject && !prev_ack) begin
          check("type_stable", int'(coinType), int'(prev_type));
          check("remaining_stable", int'(remaining), int'(prev_rem));
        end
        if (coinAck) begin
          if (exp_coin_q.size() == 0) check("extra_coin", 1, 0);
          else check("coin_type", int'(coinType), exp_coin_q.pop_front());
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) check("extra_done", 1, 0);
        else check("done_count", int'(coinCount), exp_done_q.pop_front());
        check("done_remaining", int'(remaining), 0);
        check("done_no_eject", int'(coinEject), 0);
      end
      if (error) begin
        if (exp_err_q.size() == 0) check("extra_error", 1, 0);
        else void'(exp_err_q.pop_front());
      end
      prev_eject = coinEject;
      prev_ack   = coinAck;
      prev_type  = coinType;
      prev_rem   = remaining;
    end
  end

  // Run one job; optionally fire a second request at cycle inject_at.
  task automatic run_job(input int amt, input int delay, input bit stray, input int inject_at);
    int n;
    int cyc;
    bit seen;
    ack_delay = delay;
    stray_en  = stray;
    model_push(amt, n);
    last_n = n;
    @(posedge clock); #1;
    changeIn    = 10'(amt);
    changeValid = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 3000 && !seen) begin
      @(posedge clock); #1;
      cyc++;
      changeValid = 1'b0;
      if (cyc == 1) check("busy_rise", int'(busy), 1);
      if (done) seen = 1'b1;
      else if (inject_at > 0 && cyc == inject_at) begin
        changeIn    = 10'(5 * $urandom_range(0, 200));
        changeValid = 1'b1;
        exp_err_q.push_back(1);
      end
    end
    check("done_seen", int'(seen), 1);
    check("done_latency", cyc, 1 + n * (delay + 2));
    @(posedge clock); #1;
    check("busy_fall", int'(busy), 0);
    stray_en = 1'b0;
  endtask

  // Request in IDLE with an amount that is not a multiple of 5.
  task automatic reject(input int amt);
    @(posedge clock); #1;
    changeIn    = 10'(amt);
    changeValid = 1'b1;
    exp_err_q.push_back(1);
    @(posedge clock); #1;
    changeValid = 1'b0;
    check("reject_error", int'(error), 1);
    check("reject_busy", int'(busy), 0);
    check("reject_remaining", int'(remaining), 0);
    check("reject_count", int'(coinCount), last_n);
    @(posedge clock); #1;
    check("reject_error_pulse", int'(error), 0);
  endtask

  // Stimulus and final report.
  initial begin
    int amt;
`ifdef DOLLAR_COIN_EN
    dollar_en = 1'b1;
`else
    dollar_en = 1'b0;
`endif
    reset       = 1'b1;
    changeValid = 1'b0;
    changeIn    = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_eject", int'(coinEject), 0);
    check("rst_type", int'(coinType), 0);
    check("rst_remaining", int'(remaining), 0);
    check("rst_count", int'(coinCount), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    reset = 1'b0;

    run_job(65, 0, 1'b0, 0);
    run_job(175, 0, 1'b0, 0);
    run_job(15, 5, 1'b0, 0);
    reject(37);
    run_job(50, 0, 1'b0, 2);
    run_job(0, 0, 1'b0, 0);

    // Reset while a 100-cent job waits on an unacknowledged coin.
    ack_delay = 50;
    @(posedge clock); #1;
    changeIn    = 10'd100;
    changeValid = 1'b1;
    @(posedge clock); #1;
    changeValid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("eject_before_reset", int'(coinEject), 1);
    reset = 1'b1;
    @(posedge clock); #1;
    check("mid_rst_eject", int'(coinEject), 0);
    check("mid_rst_type", int'(coinType), 0);
    check("mid_rst_remaining", int'(remaining), 0);
    check("mid_rst_count", int'(coinCount), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_error", int'(error), 0);
    reset = 1'b0;
    run_job(10, 0, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        reject(5 * $urandom_range(0, 200) + $urandom_range(1, 4));
      end else begin
        amt = 5 * $urandom_range(0, 204);
        run_job(amt, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 1) ? 1 : 0);
      end
    end

    repeat (5) @(posedge clock);
    #1;
    check("coin_q_empty", exp_coin_q.size(), 0);
    check("done_q_empty", exp_done_q.size(), 0);
    check("err_q_empty", exp_err_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
